cache_mem_arbiter: RTL and testbench

//  Shares the single main-memory word port between the ICache refill path and the DCache refill/write-back path.

---
 rtl/cache_arb_pkg.sv | 17 +
 rtl/arb_beat_cnt.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared encodings and defaults for the cache/memory arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    localparam int LINE_WORDS_DEF = 8;

endpackage

// File: rtl/arb_beat_cnt.sv
// Beat index within a line burst: cleared at grant, advanced per accepted beat, wraps at line end.
// last_o is combinational from the count; no backpressure of its own.
module arb_beat_cnt #(
    parameter int LINE_WORDS = 8,
    parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (inc_i) begin
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory word port between ICache refill and DCache refill/write-back, one line burst at a time.
// First mem_req 1 cycle after req; beats advance only on mem_ack. ARB_RR_EN selects round-robin ties (default: D wins).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int OFF_W  = BEAT_W + BYTE_W;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic              beat_clr, beat_inc, beat_last;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] beat_addr;
    logic              take_d;

    arb_beat_cnt #(
        .LINE_WORDS (LINE_WORDS),
        .BEAT_W     (BEAT_W)
    ) u_beat (
        .clk_i  (CPU_CLK),
        .rst_ni (CPU_RST_N),
        .clr_i  (beat_clr),
        .inc_i  (beat_inc),
        .beat_o (beat),
        .last_o (beat_last)
    );

    // Base is line aligned, so OR-ing the beat offset never carries past the line.
    assign beat_addr = base_q | (ADDR_W'(beat) << BYTE_W);

`ifdef ARB_RR_EN
    arb_gnt_e last_gnt_q, last_gnt_d;

    assign take_d = d_req && !(i_req && (last_gnt_q == GNT_D));

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == ARB_IDLE) begin
            if (take_d) begin
                last_gnt_d = GNT_D;
            end else if (i_req) begin
                last_gnt_d = GNT_I;
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            last_gnt_q <= GNT_I;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    assign take_d = d_req;
`endif

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q <= ARB_IDLE;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        we_d      = we_q;
        beat_clr  = 1'b0;
        beat_inc  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_wready  = 1'b0;
        d_rdata   = '0;
        d_rvalid  = 1'b0;
        d_done    = 1'b0;
        // Outputs held low while reset is asserted so an abandoned burst emits nothing.
        if (CPU_RST_N) begin
            unique case (state_q)
                ARB_IDLE: begin
                    beat_clr = 1'b1;
                    if (take_d) begin
                        state_d = ARB_GNT_D;
                        base_d  = d_addr & ~OFF_MASK;
                        we_d    = d_we;
                    end else if (i_req) begin
                        state_d = ARB_GNT_I;
                        base_d  = i_addr & ~OFF_MASK;
                        we_d    = 1'b0;
                    end
                end
                ARB_GNT_I: begin
                    mem_req  = 1'b1;
                    mem_addr = beat_addr;
                    beat_inc = mem_ack;
                    i_rvalid = mem_ack;
                    if (mem_ack) begin
                        i_rdata = mem_rdata;
                    end
                    if (mem_ack && beat_last) begin
                        i_done  = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
                ARB_GNT_D: begin
                    mem_req  = 1'b1;
                    mem_we   = we_q;
                    mem_addr = beat_addr;
                    beat_inc = mem_ack;
                    d_wready = mem_ack && we_q;
                    d_rvalid = mem_ack && !we_q;
                    if (we_q) begin
                        mem_wdata = d_wdata;
                    end
                    if (mem_ack && !we_q) begin
                        d_rdata = mem_rdata;
                    end
                    if (mem_ack && beat_last) begin
                        d_done  = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    assign arb_busy = CPU_RST_N && (state_q != ARB_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboarded bench: stimulus pushes each burst's expected beats in grant order; a monitor checks every cycle.
module tb_cache_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int LW         = 8;
    localparam int LINE_BYTES = LW * DW / 8;

    logic          CPU_CLK = 1'b0;
    logic          CPU_RST_N;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_rvalid;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_wready;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          arb_busy;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .CPU_CLK   (CPU_CLK),
        .CPU_RST_N (CPU_RST_N),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wready  (d_wready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    typedef struct packed {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    ack_mode = 0;
    logic  alt_q    = 1'b0;
`ifdef ARB_RR_EN
    logic  m_last_d = 1'b0;
`endif

    function automatic logic [DW-1:0] rfn(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [DW-1:0] wfn(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A51E69;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a granted burst is LW consecutive words from the line base.
    task automatic push_burst(input logic is_d, input logic we, input logic [AW-1:0] a);
        logic [AW-1:0] base;
        beat_t b;
        base = a - (a % LINE_BYTES);
        for (int k = 0; k < LW; k++) begin
            b.is_d = is_d;
            b.we   = we;
            b.addr = base + AW'(k * (DW / 8));
            b.data = we ? wfn(b.addr) : rfn(b.addr);
            b.last = (k == LW - 1);
            exp_q.push_back(b);
        end
`ifdef ARB_RR_EN
        m_last_d = is_d;
`endif
    endtask

    function automatic logic tie_winner_d();
`ifdef ARB_RR_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Memory responder: ack pattern per ack_mode, data is a function of the beat address.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge CPU_CLK);
            #1;
            if (mem_req) begin
                case (ack_mode)
                    0: mem_ack = 1'b1;
                    1: begin alt_q = ~alt_q; mem_ack = alt_q; end
                    default: mem_ack = ($urandom_range(0, 2) != 0);
                endcase
            end else begin
                mem_ack = 1'b0;
            end
            mem_rdata = mem_ack ? rfn(mem_addr) : 32'hDEADBEEF;
        end
    end

    // Monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge CPU_CLK);
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_req", 64'(mem_req), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("beat_addr", 64'(mem_addr), 64'(e.addr));
                    chk("beat_we", 64'(mem_we), 64'(e.we));
                    chk("beat_wdata", 64'(mem_wdata), 64'(e.we ? e.data : 32'h0));
                    if (mem_ack) begin
                        chk("beat_strobes", 64'({i_rvalid, d_rvalid, d_wready}),
                            64'({!e.is_d, e.is_d && !e.we, e.is_d && e.we}));
                        if (!e.we) begin
                            chk("beat_rdata", 64'(e.is_d ? d_rdata : i_rdata), 64'(e.data));
                        end
                        chk("beat_done", 64'({i_done, d_done}),
                            64'({e.last && !e.is_d, e.last && e.is_d}));
                        void'(exp_q.pop_front());
                    end else begin
                        chk("wait_strobes", 64'({i_rvalid, d_rvalid, d_wready, i_done, d_done}), 64'(0));
                    end
                end
            end else begin
                chk("idle_strobes", 64'({i_rvalid, d_rvalid, d_wready, i_done, d_done, mem_we}), 64'(0));
            end
            chk("busy_vs_req", 64'(arb_busy), 64'(mem_req));
        end
    end

    task automatic run_i(input logic [AW-1:0] a);
        int   n;
        logic got;
        i_addr = a;
        i_req  = 1'b1;
        got    = 1'b0;
        n      = 0;
        while (!got && n < 400) begin
            @(negedge CPU_CLK);
            got = i_done;
            n++;
        end
        #2;
        i_req = 1'b0;
        chk("i_done_seen", 64'(got), 64'(1));
    endtask

    task automatic run_d(input logic [AW-1:0] a, input logic we);
        int            n;
        logic          got, wr;
        logic [AW-1:0] nxt;
        nxt     = a - (a % LINE_BYTES);
        d_addr  = a;
        d_we    = we;
        d_wdata = we ? wfn(nxt) : $urandom;
        d_req   = 1'b1;
        got     = 1'b0;
        n       = 0;
        while (!got && n < 400) begin
            @(negedge CPU_CLK);
            wr  = d_wready;
            got = d_done;
            n++;
            #2;
            if (wr) begin
                nxt     = nxt + AW'(DW / 8);
                d_wdata = wfn(nxt);
            end
        end
        d_req = 1'b0;
        chk("d_done_seen", 64'(got), 64'(1));
    endtask

    task automatic gap_chk(input string nm);
        @(negedge CPU_CLK);
        chk(nm, 64'(mem_req), 64'(0));
        @(negedge CPU_CLK);
        chk(nm, 64'(mem_req), 64'(1));
    endtask

    task automatic tie(input logic [AW-1:0] ai, input logic [AW-1:0] ad, input logic we);
        logic wd;
        wd = tie_winner_d();
        if (wd) begin
            push_burst(1'b1, we, ad);
            push_burst(1'b0, 1'b0, ai);
        end else begin
            push_burst(1'b0, 1'b0, ai);
            push_burst(1'b1, we, ad);
        end
        fork
            begin run_i(ai); if (!wd) gap_chk("tie_gap_after_i"); end
            begin run_d(ad, we); if (wd) gap_chk("tie_gap_after_d"); end
        join
    endtask

    initial begin
        int   cnt, n;
        logic got;
        logic [AW-1:0] a1, a2;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        CPU_RST_N = 1'b0;
        repeat (3) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        chk("reset_outputs", 64'({mem_req, mem_we, arb_busy, i_rvalid, i_done, d_rvalid, d_wready, d_done}), 64'(0));
        chk("reset_addr", 64'(mem_addr), 64'(0));
        #2;
        CPU_RST_N = 1'b1;

        // Single I refill, ack every cycle
        ack_mode = 0;
        push_burst(1'b0, 1'b0, 32'h104);
        fork
            run_i(32'h104);
            begin
                @(negedge CPU_CLK);
                chk("req_latency", 64'(mem_req), 64'(1));
            end
        join
        @(negedge CPU_CLK);
        chk("gap_after_burst", 64'({mem_req, arb_busy}), 64'(0));
        #2;

        tie(32'h1000, 32'h2040, 1'b0);
        ack_mode = 1;
        push_burst(1'b1, 1'b1, 32'h2000);
        run_d(32'h2000, 1'b1);
        ack_mode = 2;
        tie(32'h5010, 32'h6000, 1'b1);
        tie(32'h7000, 32'h8004, 1'b0);

        // Reset mid-burst, then a fresh request restarts at beat 0
        ack_mode = 0;
        push_burst(1'b0, 1'b0, 32'h300);
        i_addr = 32'h300;
        i_req  = 1'b1;
        cnt = 0;
        n   = 0;
        while (cnt < 3 && n < 400) begin
            @(negedge CPU_CLK);
            if (i_rvalid) cnt++;
            n++;
        end
        #2;
        CPU_RST_N = 1'b0;
        i_req = 1'b0;
        exp_q.delete();
`ifdef ARB_RR_EN
        m_last_d = 1'b0;
`endif
        @(negedge CPU_CLK);
        chk("rst_mid_burst_idle", 64'({mem_req, arb_busy, i_rvalid}), 64'(0));
        #2;
        CPU_RST_N = 1'b1;
        push_burst(1'b0, 1'b0, 32'h300);
        run_i(32'h300);

        // D refill with req dropped after two beats
        ack_mode = 2;
        push_burst(1'b1, 1'b0, 32'h4400);
        d_addr = 32'h4400;
        d_we   = 1'b0;
        d_req  = 1'b1;
        cnt = 0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge CPU_CLK);
            if (d_rvalid) cnt++;
            got = d_done;
            n++;
            #2;
            if (cnt >= 2) d_req = 1'b0;
        end
        d_req = 1'b0;
        chk("drop_d_done_seen", 64'(got), 64'(1));
        chk("drop_beats", 64'(cnt), 64'(LW));
        repeat (3) begin
            @(negedge CPU_CLK);
            chk("no_regrant", 64'({mem_req, arb_busy}), 64'(0));
        end
        #2;

        for (int it = 0; it < 16; it++) begin
            logic we;
            int   kind;
            ack_mode = $urandom_range(0, 2);
            kind     = $urandom_range(0, 3);
            a1       = $urandom;
            a2       = $urandom;
            we       = 1'($urandom_range(0, 1));
            case (kind)
                0: begin push_burst(1'b0, 1'b0, a1); run_i(a1); end
                1: begin push_burst(1'b1, we, a2); run_d(a2, we); end
                default: tie(a1, a2, we);
            endcase
            @(negedge CPU_CLK);
            #2;
        end

        repeat (3) @(negedge CPU_CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
